// File: rtl/cpu_exec_seq_pkg.sv
// Shared definitions for the execute-stage sequencer: operation codes,
// flag bit positions, B-source selects, FSM states and op-class helpers.
package cpu_exec_seq_pkg;

   // Operation encodings shared with the combinational ALU.
   // Codes 4'hC..4'hF are undefined.
   localparam logic [3:0] OP_PASS_A      = 4'h0;
   localparam logic [3:0] OP_PASS_B      = 4'h1;
   localparam logic [3:0] OP_ADD         = 4'h2;
   localparam logic [3:0] OP_SUB         = 4'h3;
   localparam logic [3:0] OP_AND         = 4'h4;
   localparam logic [3:0] OP_OR          = 4'h5;
   localparam logic [3:0] OP_XOR         = 4'h6;
   localparam logic [3:0] OP_SHL_A       = 4'h7;
   localparam logic [3:0] OP_SHR_A       = 4'h8;
   localparam logic [3:0] OP_INC_REG_A   = 4'h9;
   localparam logic [3:0] OP_DEC_REG_A   = 4'hA;
   localparam logic [3:0] OP_MOVE_REG_XA = 4'hB;

   // Bit positions inside the {N,V,C,Z} flag vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

   // ALU B operand source.
   localparam logic B_SEL_X   = 1'b0;
   localparam logic B_SEL_IMM = 1'b1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   // Shift ops iterate once per count step through the ALU.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SHL_A) || (op == OP_SHR_A);
   endfunction

   // Ops whose carry output is architecturally meaningful.
   function automatic logic updates_c(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL_A) ||
             (op == OP_SHR_A) || (op == OP_INC_REG_A) || (op == OP_DEC_REG_A);
   endfunction

   // Only two's-complement add/subtract produce a meaningful overflow.
   function automatic logic updates_v(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Any code above the last defined op performs no write at all.
   function automatic logic is_defined_op(input logic [3:0] op);
      return op <= OP_MOVE_REG_XA;
   endfunction

   // The only op whose destination is X rather than A.
   function automatic logic writes_x(input logic [3:0] op);
      return op == OP_MOVE_REG_XA;
   endfunction

endpackage

// File: rtl/cpu_exec_seq_flag_reg.sv
// Four-bit {N,V,C,Z} flag register; each bit loads only when its own
// write enable is set, otherwise it holds.
module cpu_flag_reg
   import cpu_exec_seq_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] we_i,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);

   logic [3:0] flags_d;
   logic [3:0] flags_q;

   // Per-bit select between the held value and the incoming flag.
   always_comb begin
      flags_d = flags_q;
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) begin
            flags_d[i] = d_i[i];
         end
      end
   end

   // Flag storage, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign q_o = flags_q;

endmodule

// File: rtl/cpu_exec_seq.sv
// Execute-stage sequencer: accepts one decoded ALU instruction, drives the
// external ALU from latched operands, and writes result and flags back to
// A or X. Shifts loop through the ALU one bit per cycle.
module cpu_exec_seq
   import cpu_exec_seq_pkg::*;
#(
   parameter logic [7:0] ACC_RST_VAL = 8'h00,
   parameter logic [7:0] X_RST_VAL   = 8'h00,
   parameter int         CNT_W       = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       op_i,
   input  logic             b_sel_i,
   input  logic [7:0]       imm_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             abort_i,
   output logic [7:0]       alu_a_o,
   output logic [7:0]       alu_b_o,
   output logic [3:0]       alu_op_o,
   input  logic [7:0]       alu_y_i,
   input  logic [3:0]       alu_flags_i,
   output logic [7:0]       acc_o,
   output logic [7:0]       x_o,
   output logic [3:0]       flags_o,
   output logic             busy_o,
   output logic             done_o
);

   state_e           state_d, state_q;
   logic [3:0]       op_d, op_q;
   logic [7:0]       b_d, b_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [7:0]       acc_d, acc_q;
   logic [7:0]       x_d, x_q;
   logic             done_d, done_q;
   logic [3:0]       flag_we;

   // Next-state, writeback and handshake decode for the IDLE/EXEC machine.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      x_d        = x_q;
      done_d     = 1'b0;
      flag_we    = 4'b0000;
      in_ready_o = 1'b0;
      busy_o     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               op_d    = op_i;
               // B is captured at acceptance so a later X write cannot
               // disturb an instruction already in flight.
               b_d     = (b_sel_i == B_SEL_IMM) ? imm_i : x_q;
               cnt_d   = is_shift(op_i) ? cnt_i : '0;
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            busy_o = 1'b1;
            if (abort_i) begin
               // Earlier shift iterations stay committed; only this
               // cycle's write is dropped.
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               if (is_defined_op(op_q)) begin
                  if (writes_x(op_q)) begin
                     x_d = alu_y_i;
                  end else begin
                     acc_d = alu_y_i;
                  end
                  flag_we[FLAG_N] = 1'b1;
                  flag_we[FLAG_Z] = 1'b1;
                  flag_we[FLAG_C] = updates_c(op_q);
                  flag_we[FLAG_V] = updates_v(op_q);
               end
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Architectural registers and instruction latches.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         op_q    <= OP_PASS_A;
         b_q     <= 8'h00;
         cnt_q   <= '0;
         acc_q   <= ACC_RST_VAL;
         x_q     <= X_RST_VAL;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         done_q  <= done_d;
      end
   end

   cpu_flag_reg u_flag_reg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (flag_we),
      .d_i    (alu_flags_i),
      .q_o    (flags_o)
   );

   // A always feeds the ALU directly so each shift iteration sees the
   // value written by the previous one.
   assign alu_a_o  = acc_q;
   assign alu_b_o  = b_q;
   assign alu_op_o = op_q;
   assign acc_o    = acc_q;
   assign x_o      = x_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_cpu_exec_seq.sv
// Directed bench for cpu_exec_seq with a behavioural 8-bit ALU closing
// the loop between alu_*_o and alu_*_i.
module tb_cpu_exec_seq;
   import cpu_exec_seq_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       in_valid_i;
   logic       in_ready_o;
   logic [3:0] op_i;
   logic       b_sel_i;
   logic [7:0] imm_i;
   logic [2:0] cnt_i;
   logic       abort_i;
   logic [7:0] alu_a_o, alu_b_o, alu_y_i;
   logic [3:0] alu_op_o, alu_flags_i;
   logic [7:0] acc_o, x_o;
   logic [3:0] flags_o;
   logic       busy_o, done_o;

   int n_vec = 0;
   int n_err = 0;

   cpu_exec_seq dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .b_sel_i     (b_sel_i),
      .imm_i       (imm_i),
      .cnt_i       (cnt_i),
      .abort_i     (abort_i),
      .alu_a_o     (alu_a_o),
      .alu_b_o     (alu_b_o),
      .alu_op_o    (alu_op_o),
      .alu_y_i     (alu_y_i),
      .alu_flags_i (alu_flags_i),
      .acc_o       (acc_o),
      .x_o         (x_o),
      .flags_o     (flags_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference ALU. Ops that must not touch V drive v=1 and logic/pass ops
   // drive c=0, so any wrongly enabled flag write shows up. Undefined ops
   // produce a distinctive result and all-ones flags.
   logic [8:0] wide;
   logic       c_o, v_o;
   always_comb begin
      wide    = 9'h000;
      c_o     = 1'b0;
      v_o     = 1'b1;
      alu_y_i = 8'h00;
      case (alu_op_o)
         OP_PASS_A:      alu_y_i = alu_a_o;
         OP_PASS_B:      alu_y_i = alu_b_o;
         OP_ADD: begin
            wide    = {1'b0, alu_a_o} + {1'b0, alu_b_o};
            alu_y_i = wide[7:0];
            c_o     = wide[8];
            v_o     = (alu_a_o[7] == alu_b_o[7]) && (alu_y_i[7] != alu_a_o[7]);
         end
         OP_SUB: begin
            alu_y_i = alu_a_o - alu_b_o;
            c_o     = alu_a_o < alu_b_o;
            v_o     = (alu_a_o[7] != alu_b_o[7]) && (alu_y_i[7] != alu_a_o[7]);
         end
         OP_AND:         alu_y_i = alu_a_o & alu_b_o;
         OP_OR:          alu_y_i = alu_a_o | alu_b_o;
         OP_XOR:         alu_y_i = alu_a_o ^ alu_b_o;
         OP_SHL_A: begin
            alu_y_i = {alu_a_o[6:0], 1'b0};
            c_o     = alu_a_o[7];
         end
         OP_SHR_A: begin
            alu_y_i = {1'b0, alu_a_o[7:1]};
            c_o     = alu_a_o[0];
         end
         OP_INC_REG_A: begin
            alu_y_i = alu_a_o + 8'h01;
            c_o     = alu_a_o == 8'hFF;
         end
         OP_DEC_REG_A: begin
            alu_y_i = alu_a_o - 8'h01;
            c_o     = alu_a_o == 8'h00;
         end
         OP_MOVE_REG_XA: alu_y_i = alu_a_o;
         default:        alu_y_i = 8'hEE;
      endcase
      if (alu_op_o > OP_MOVE_REG_XA) begin
         alu_flags_i = 4'b1111;
      end else begin
         alu_flags_i = {alu_y_i[7], v_o, c_o, alu_y_i == 8'h00};
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one instruction from IDLE and count cycles until done_o.
   task automatic exec(input logic [3:0] op, input logic bsel, input logic [7:0] imm,
                       input logic [2:0] cnt, input int exp_n, input string tag);
      int n;
      n          = 0;
      in_valid_i = 1'b1;
      op_i       = op;
      b_sel_i    = bsel;
      imm_i      = imm;
      cnt_i      = cnt;
      tick();
      in_valid_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (done_o) break;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_n));
   endtask

   initial begin
      rst_ni     = 1'b0;
      in_valid_i = 1'b0;
      op_i       = OP_PASS_A;
      b_sel_i    = B_SEL_X;
      imm_i      = 8'h00;
      cnt_i      = 3'd0;
      abort_i    = 1'b0;
      tick();
      tick();
      chk("rst_acc", 32'(acc_o), 32'h00);
      chk("rst_x", 32'(x_o), 32'h00);
      chk("rst_flags", 32'(flags_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_ready", 32'(in_ready_o), 32'h1);
      chk("rst_done", 32'(done_o), 32'h0);
      rst_ni = 1'b1;
      tick();

      // Set up A=0x7F, X=0x01.
      exec(OP_PASS_B, B_SEL_IMM, 8'h01, 3'd0, 1, "ld_a1");
      exec(OP_MOVE_REG_XA, B_SEL_X, 8'h00, 3'd0, 1, "mov_x1");
      chk("setup_x", 32'(x_o), 32'h01);
      exec(OP_PASS_B, B_SEL_IMM, 8'h7F, 3'd0, 1, "ld_a7f");
      chk("setup_a", 32'(acc_o), 32'h7F);

      // ADD A+X, stepped cycle by cycle.
      in_valid_i = 1'b1; op_i = OP_ADD; b_sel_i = B_SEL_X; imm_i = 8'hAA;
      tick();
      in_valid_i = 1'b0;
      chk("add_exec_ready", 32'(in_ready_o), 32'h0);
      chk("add_exec_busy", 32'(busy_o), 32'h1);
      chk("add_exec_acc", 32'(acc_o), 32'h7F);
      chk("add_exec_done", 32'(done_o), 32'h0);
      tick();
      chk("add_acc", 32'(acc_o), 32'h80);
      chk("add_flags", 32'(flags_o), 32'b1100);
      chk("add_done", 32'(done_o), 32'h1);
      chk("add_ready", 32'(in_ready_o), 32'h1);
      tick();
      chk("add_done_once", 32'(done_o), 32'h0);
      chk("add_one_write", 32'(acc_o), 32'h80);

      // SHL cnt=2 on 0x81 with in_valid_i held high throughout.
      exec(OP_PASS_B, B_SEL_IMM, 8'h81, 3'd0, 1, "ld_a81");
      chk("pass_keeps_cv", 32'(flags_o), 32'b1100);
      in_valid_i = 1'b1; op_i = OP_SHL_A; b_sel_i = B_SEL_IMM; imm_i = 8'h00; cnt_i = 3'd2;
      tick();
      chk("shl_acc0", 32'(acc_o), 32'h81);
      tick();
      chk("shl_acc1", 32'(acc_o), 32'h02);
      chk("shl_flags1", 32'(flags_o), 32'b0110);
      chk("shl_busy1", 32'(busy_o), 32'h1);
      chk("shl_done1", 32'(done_o), 32'h0);
      tick();
      chk("shl_acc2", 32'(acc_o), 32'h04);
      chk("shl_flags2", 32'(flags_o), 32'b0100);
      chk("shl_ready2", 32'(in_ready_o), 32'h0);
      op_i = OP_PASS_A; cnt_i = 3'd0;
      tick();
      chk("shl_acc3", 32'(acc_o), 32'h08);
      chk("shl_flags3", 32'(flags_o), 32'b0100);
      chk("shl_done3", 32'(done_o), 32'h1);
      chk("shl_ready3", 32'(in_ready_o), 32'h1);
      tick();
      in_valid_i = 1'b0;
      chk("shl_done_once", 32'(done_o), 32'h0);
      chk("shl_next_busy", 32'(busy_o), 32'h1);
      chk("shl_no_extra", 32'(acc_o), 32'h08);
      tick();
      chk("pass_a_done", 32'(done_o), 32'h1);
      chk("pass_a_acc", 32'(acc_o), 32'h08);

      // SUB borrow, then AND preserves C and V.
      exec(OP_PASS_B, B_SEL_IMM, 8'h00, 3'd0, 1, "ld_a00");
      chk("ld0_flags", 32'(flags_o), 32'b0101);
      exec(OP_SUB, B_SEL_IMM, 8'h01, 3'd0, 1, "sub");
      chk("sub_acc", 32'(acc_o), 32'hFF);
      chk("sub_flags", 32'(flags_o), 32'b1010);
      exec(OP_AND, B_SEL_IMM, 8'h0F, 3'd0, 1, "and");
      chk("and_acc", 32'(acc_o), 32'h0F);
      chk("and_flags", 32'(flags_o), 32'b0010);

      // MOVE to X and an undefined op.
      exec(OP_PASS_B, B_SEL_IMM, 8'h55, 3'd0, 1, "ld_a55");
      exec(OP_MOVE_REG_XA, B_SEL_X, 8'h00, 3'd0, 1, "mov_x55");
      chk("mov55_x", 32'(x_o), 32'h55);
      exec(OP_PASS_B, B_SEL_IMM, 8'h00, 3'd0, 1, "ld_a0b");
      exec(OP_MOVE_REG_XA, B_SEL_X, 8'h00, 3'd0, 1, "mov_x0");
      chk("mov_x", 32'(x_o), 32'h00);
      chk("mov_a", 32'(acc_o), 32'h00);
      chk("mov_flags", 32'(flags_o), 32'b0011);
      exec(4'hF, B_SEL_IMM, 8'hAA, 3'd5, 1, "undef");
      chk("undef_a", 32'(acc_o), 32'h00);
      chk("undef_x", 32'(x_o), 32'h00);
      chk("undef_flags", 32'(flags_o), 32'b0011);

      // SHR cnt=3, aborted in the second EXEC cycle.
      exec(OP_PASS_B, B_SEL_IMM, 8'h80, 3'd0, 1, "ld_a80");
      chk("ld80_flags", 32'(flags_o), 32'b1010);
      in_valid_i = 1'b1; op_i = OP_SHR_A; cnt_i = 3'd3;
      tick();
      in_valid_i = 1'b0;
      tick();
      chk("shr_acc1", 32'(acc_o), 32'h40);
      chk("shr_flags1", 32'(flags_o), 32'b0000);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_acc", 32'(acc_o), 32'h40);
      chk("abort_flags", 32'(flags_o), 32'b0000);
      chk("abort_busy", 32'(busy_o), 32'h0);
      chk("abort_ready", 32'(in_ready_o), 32'h1);
      chk("abort_done", 32'(done_o), 32'h0);
      tick();
      chk("abort_done2", 32'(done_o), 32'h0);
      chk("abort_acc2", 32'(acc_o), 32'h40);

      // Asynchronous reset in the middle of a shift.
      exec(OP_PASS_B, B_SEL_IMM, 8'h11, 3'd0, 1, "ld_a11");
      exec(OP_MOVE_REG_XA, B_SEL_X, 8'h00, 3'd0, 1, "mov_x11");
      in_valid_i = 1'b1; op_i = OP_SHL_A; cnt_i = 3'd3;
      tick();
      in_valid_i = 1'b0;
      tick();
      chk("rshl_acc1", 32'(acc_o), 32'h22);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mrst_acc", 32'(acc_o), 32'h00);
      chk("mrst_x", 32'(x_o), 32'h00);
      chk("mrst_flags", 32'(flags_o), 32'h0);
      chk("mrst_busy", 32'(busy_o), 32'h0);
      chk("mrst_ready", 32'(in_ready_o), 32'h1);
      chk("mrst_done", 32'(done_o), 32'h0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("post_rst_done", 32'(done_o), 32'h0);
      chk("post_rst_acc", 32'(acc_o), 32'h00);

      // INC/DEC after reset.
      exec(OP_INC_REG_A, B_SEL_X, 8'h00, 3'd0, 1, "inc");
      chk("inc_acc", 32'(acc_o), 32'h01);
      chk("inc_flags", 32'(flags_o), 32'b0000);
      exec(OP_DEC_REG_A, B_SEL_X, 8'h00, 3'd0, 1, "dec1");
      chk("dec1_flags", 32'(flags_o), 32'b0001);
      exec(OP_DEC_REG_A, B_SEL_X, 8'h00, 3'd0, 1, "dec2");
      chk("dec2_acc", 32'(acc_o), 32'hFF);
      chk("dec2_flags", 32'(flags_o), 32'b1010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
